ahb_cmd_manager: RTL and testbench

// AHB-lite manager: converts a valid/ready command stream into single AHB-lite transfers.

---
 rtl/ahb_cmd_manager.sv | 157 +++++++++++++++
 tb/tb_ahb_cmd_manager.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cmd_manager.sv
// ahb_cmd_manager
// Turns a valid/ready command stream into single AHB-lite transfers. The
// address phase of the next command overlaps the data phase of the current
// one, so an unstalled subordinate sees one transfer per cycle.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_valid must not depend on cmd_ready. The response side has no
// backpressure: rsp_valid is a one-cycle pulse per completed transfer, and
// responses come back in command order.
module ahb_cmd_manager #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [W_ADDR-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [W_DATA-1:0] cmd_wdata,
  // response stream
  output logic              rsp_valid,
  output logic [W_DATA-1:0] rsp_rdata,
  output logic              rsp_err,
  // AHB-lite manager
  output logic [W_ADDR-1:0] ahbm_haddr,
  output logic              ahbm_hwrite,
  output logic [2:0]        ahbm_hsize,
  output logic [1:0]        ahbm_htrans,
  output logic [W_DATA-1:0] ahbm_hwdata,
  output logic [2:0]        ahbm_hburst,
  output logic [3:0]        ahbm_hprot,
  output logic              ahbm_hmastlock,
  input  logic              ahbm_hready,
  input  logic              ahbm_hresp,
  input  logic [W_DATA-1:0] ahbm_hrdata
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // address-phase register
  logic              aph_vld_q,   aph_vld_d;
  logic [W_ADDR-1:0] aph_addr_q,  aph_addr_d;
  logic              aph_write_q, aph_write_d;
  logic [2:0]        aph_size_q,  aph_size_d;
  logic [W_DATA-1:0] aph_wdata_q, aph_wdata_d;
  // data-phase register
  logic              dph_vld_q,   dph_vld_d;
  logic              dph_write_q, dph_write_d;
  logic [W_DATA-1:0] dph_wdata_q, dph_wdata_d;
  // set during the first cycle of a two-cycle ERROR response; the pending
  // address phase is withdrawn (IDLE) for the second cycle and reissued after
  logic              err_cancel_q, err_cancel_d;
  // response register
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [W_DATA-1:0] rsp_rdata_q, rsp_rdata_d;

  logic advance;
  logic cmd_accept;
  logic complete;

  assign advance    = ahbm_hready && !err_cancel_q;
  assign cmd_ready  = !aph_vld_q || advance;
  assign cmd_accept = cmd_valid && cmd_ready;
  assign complete   = dph_vld_q && ahbm_hready;

  // Next-state for the pipeline, error cancel flag and response registers
  always_comb begin
    aph_vld_d    = aph_vld_q;
    aph_addr_d   = aph_addr_q;
    aph_write_d  = aph_write_q;
    aph_size_d   = aph_size_q;
    aph_wdata_d  = aph_wdata_q;
    dph_vld_d    = dph_vld_q;
    dph_write_d  = dph_write_q;
    dph_wdata_d  = dph_wdata_q;
    err_cancel_d = err_cancel_q;

    // Address phase: take a new command, or empty out once the held one moves on.
    if (cmd_accept) begin
      aph_vld_d   = 1'b1;
      aph_addr_d  = cmd_addr;
      aph_write_d = cmd_write;
      aph_size_d  = cmd_size;
      aph_wdata_d = cmd_wdata;
    end else if (advance) begin
      aph_vld_d = 1'b0;
    end

    // Data phase: follows the address phase on advance; a completion that
    // happens without advance (second error cycle) just retires it.
    if (advance) begin
      dph_vld_d   = aph_vld_q;
      dph_write_d = aph_write_q;
      dph_wdata_d = aph_wdata_q;
    end else if (complete) begin
      dph_vld_d = 1'b0;
    end

    if (ahbm_hready) begin
      err_cancel_d = 1'b0;
    end else if (dph_vld_q && ahbm_hresp) begin
      err_cancel_d = 1'b1;
    end

    rsp_valid_d = complete;
    rsp_err_d   = complete && ahbm_hresp;
    rsp_rdata_d = (complete && !dph_write_q) ? ahbm_hrdata : '0;
  end

  // Control state: synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aph_vld_q    <= 1'b0;
      dph_vld_q    <= 1'b0;
      err_cancel_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      aph_vld_q    <= aph_vld_d;
      dph_vld_q    <= dph_vld_d;
      err_cancel_q <= err_cancel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  // Address/data payload: qualified by the valid bits, so no reset needed
  always_ff @(posedge clk) begin
    aph_addr_q  <= aph_addr_d;
    aph_write_q <= aph_write_d;
    aph_size_q  <= aph_size_d;
    aph_wdata_q <= aph_wdata_d;
    dph_write_q <= dph_write_d;
    dph_wdata_q <= dph_wdata_d;
  end

  assign ahbm_htrans    = (aph_vld_q && !err_cancel_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahbm_haddr     = aph_addr_q;
  assign ahbm_hwrite    = aph_write_q;
  assign ahbm_hsize     = aph_size_q;
  assign ahbm_hwdata    = dph_wdata_q;
  assign ahbm_hburst    = 3'b000;
  assign ahbm_hprot     = 4'b0011;
  assign ahbm_hmastlock = 1'b0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_cmd_manager.sv
// Directed bench for ahb_cmd_manager. Inputs change 1ns after each rising
// edge; outputs are checked on the falling edge. "cycle k" below means the
// period following rising edge k of a test, with the command offered in cycle 0.
module tb_ahb_cmd_manager;

  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [W_ADDR-1:0] cmd_addr;
  logic              cmd_write;
  logic [2:0]        cmd_size;
  logic [W_DATA-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [W_DATA-1:0] rsp_rdata;
  logic              rsp_err;
  logic [W_ADDR-1:0] ahbm_haddr;
  logic              ahbm_hwrite;
  logic [2:0]        ahbm_hsize;
  logic [1:0]        ahbm_htrans;
  logic [W_DATA-1:0] ahbm_hwdata;
  logic [2:0]        ahbm_hburst;
  logic [3:0]        ahbm_hprot;
  logic              ahbm_hmastlock;
  logic              ahbm_hready;
  logic              ahbm_hresp;
  logic [W_DATA-1:0] ahbm_hrdata;

  int tests_run;
  int tests_failed;

  ahb_cmd_manager #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ahbm_haddr(ahbm_haddr), .ahbm_hwrite(ahbm_hwrite), .ahbm_hsize(ahbm_hsize),
    .ahbm_htrans(ahbm_htrans), .ahbm_hwdata(ahbm_hwdata), .ahbm_hburst(ahbm_hburst),
    .ahbm_hprot(ahbm_hprot), .ahbm_hmastlock(ahbm_hmastlock),
    .ahbm_hready(ahbm_hready), .ahbm_hresp(ahbm_hresp), .ahbm_hrdata(ahbm_hrdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic [W_ADDR-1:0] a, input logic w,
                           input logic [2:0] s, input logic [W_DATA-1:0] d);
    cmd_valid = v; cmd_addr = a; cmd_write = w; cmd_size = s; cmd_wdata = d;
  endtask

  task automatic drive_bus(input logic rdy, input logic rsp, input logic [W_DATA-1:0] rd);
    ahbm_hready = rdy; ahbm_hresp = rsp; ahbm_hrdata = rd;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      drive_cmd(1'b0, '0, 1'b0, 3'd0, '0);
      drive_bus(1'b1, 1'b0, '0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_cmd(1'b0, '0, 1'b0, 3'd0, '0);
    drive_bus(1'b1, 1'b0, '0);
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (ahbm_htrans !== IDLE) begin tests_failed++; $display("FAIL rst_htrans got %h exp %h", ahbm_htrans, IDLE); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_err got %b exp 0", rsp_err); end
    tests_run++; if (rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_rsp_rdata got %h exp 0", rsp_rdata); end
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    tests_run++; if (ahbm_hburst !== 3'b000 || ahbm_hprot !== 4'b0011 || ahbm_hmastlock !== 1'b0) begin
      tests_failed++; $display("FAIL rst_consts got burst=%h prot=%h lock=%b exp 0/3/0", ahbm_hburst, ahbm_hprot, ahbm_hmastlock);
    end
  endtask

  task automatic test_single_write();
    tick(); drive_cmd(1'b1, 32'h1000, 1'b1, 3'd2, 32'hDEADBEEF); drive_bus(1'b1, 1'b0, '0);
    @(negedge clk);
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL wr_cmd_ready got %b exp 1", cmd_ready); end
    tick(); drive_cmd(1'b0, '0, 1'b0, 3'd0, '0);
    @(negedge clk); // cycle 1: address phase
    tests_run++; if (ahbm_htrans !== NONSEQ || ahbm_haddr !== 32'h1000 || ahbm_hwrite !== 1'b1 || ahbm_hsize !== 3'd2) begin
      tests_failed++; $display("FAIL wr_aphase got trans=%h addr=%h wr=%b size=%0d exp 2/1000/1/2", ahbm_htrans, ahbm_haddr, ahbm_hwrite, ahbm_hsize);
    end
    tick(); @(negedge clk); // cycle 2: data phase
    tests_run++; if (ahbm_hwdata !== 32'hDEADBEEF || ahbm_htrans !== IDLE) begin
      tests_failed++; $display("FAIL wr_dphase got hwdata=%h trans=%h exp deadbeef/0", ahbm_hwdata, ahbm_htrans);
    end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL wr_rsp_early got %b exp 0", rsp_valid); end
    tick(); @(negedge clk); // cycle 3: response
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      tests_failed++; $display("FAIL wr_rsp got v=%b err=%b rdata=%h exp 1/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    tick(); @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL wr_rsp_pulse got %b exp 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]        exp_trans;
    logic              exp_rv;
    logic [W_DATA-1:0] exp_rd;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 4) drive_cmd(1'b1, 32'(i * 4), 1'b0, 3'd2, '0);
      else       drive_cmd(1'b0, '0, 1'b0, 3'd0, '0);
      // read at address 4*k returns 0x1111_0000+k during its data phase (cycle k+2)
      if (i >= 2 && i < 6) drive_bus(1'b1, 1'b0, 32'h1111_0000 + 32'(i - 2));
      else                 drive_bus(1'b1, 1'b0, '0);
      @(negedge clk);
      exp_trans = (i >= 1 && i <= 4) ? NONSEQ : IDLE;
      tests_run++; if (ahbm_htrans !== exp_trans) begin tests_failed++; $display("FAIL b2b_htrans c%0d got %h exp %h", i, ahbm_htrans, exp_trans); end
      if (i >= 1 && i <= 4) begin
        tests_run++; if (ahbm_haddr !== 32'((i - 1) * 4)) begin tests_failed++; $display("FAIL b2b_haddr c%0d got %h exp %h", i, ahbm_haddr, 32'((i - 1) * 4)); end
      end
      exp_rv = (i >= 3 && i <= 6);
      exp_rd = exp_rv ? 32'h1111_0000 + 32'(i - 3) : '0;
      tests_run++; if (rsp_valid !== exp_rv || rsp_rdata !== exp_rd || rsp_err !== 1'b0) begin
        tests_failed++; $display("FAIL b2b_rsp c%0d got v=%b rdata=%h err=%b exp %b/%h/0", i, rsp_valid, rsp_rdata, rsp_err, exp_rv, exp_rd);
      end
    end
  endtask

  task automatic test_wait_states();
    tick(); drive_cmd(1'b1, 32'h20, 1'b0, 3'd2, '0); drive_bus(1'b1, 1'b0, '0);
    tick(); drive_cmd(1'b1, 32'h24, 1'b0, 3'd2, '0);
    @(negedge clk);
    tests_run++; if (ahbm_haddr !== 32'h20 || ahbm_htrans !== NONSEQ) begin tests_failed++; $display("FAIL ws_aphase got addr=%h trans=%h exp 20/2", ahbm_haddr, ahbm_htrans); end
    // cycles 2..4: data phase of 0x20 stalled, 0x24 held in address phase
    for (int i = 2; i <= 4; i++) begin
      tick(); drive_cmd(1'b0, '0, 1'b0, 3'd0, '0); drive_bus(1'b0, 1'b0, 32'hBAD0_0000);
      @(negedge clk);
      tests_run++; if (ahbm_haddr !== 32'h24 || ahbm_htrans !== NONSEQ || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        tests_failed++; $display("FAIL ws_hold c%0d got addr=%h trans=%h rdy=%b rv=%b exp 24/2/0/0", i, ahbm_haddr, ahbm_htrans, cmd_ready, rsp_valid);
      end
    end
    tick(); drive_bus(1'b1, 1'b0, 32'hCAFE0020); @(negedge clk); // cycle 5
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL ws_rsp_early got %b exp 0", rsp_valid); end
    tick(); drive_bus(1'b1, 1'b0, 32'hCAFE0024); @(negedge clk); // cycle 6
    tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE0020) begin tests_failed++; $display("FAIL ws_rsp0 got v=%b rdata=%h exp 1/cafe0020", rsp_valid, rsp_rdata); end
    tick(); drive_bus(1'b1, 1'b0, '0); @(negedge clk); // cycle 7
    tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE0024) begin tests_failed++; $display("FAIL ws_rsp1 got v=%b rdata=%h exp 1/cafe0024", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_error();
    tick(); drive_cmd(1'b1, 32'h40, 1'b1, 3'd2, 32'h0000_0055); drive_bus(1'b1, 1'b0, '0);
    tick(); drive_cmd(1'b1, 32'h44, 1'b0, 3'd2, '0);
    tick(); drive_cmd(1'b0, '0, 1'b0, 3'd0, '0); drive_bus(1'b0, 1'b1, '0); // cycle 2: first error cycle
    @(negedge clk);
    tests_run++; if (ahbm_hwdata !== 32'h55 || ahbm_htrans !== NONSEQ || ahbm_haddr !== 32'h44) begin
      tests_failed++; $display("FAIL err_c2 got hwdata=%h trans=%h addr=%h exp 55/2/44", ahbm_hwdata, ahbm_htrans, ahbm_haddr);
    end
    tick(); drive_bus(1'b1, 1'b1, '0); @(negedge clk); // cycle 3: second error cycle
    tests_run++; if (ahbm_htrans !== IDLE) begin tests_failed++; $display("FAIL err_cancel_htrans got %h exp 0", ahbm_htrans); end
    tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL err_cancel_ready got %b exp 0", cmd_ready); end
    tick(); drive_bus(1'b1, 1'b0, '0); @(negedge clk); // cycle 4: reissue
    tests_run++; if (ahbm_htrans !== NONSEQ || ahbm_haddr !== 32'h44 || ahbm_hwrite !== 1'b0) begin
      tests_failed++; $display("FAIL err_reissue got trans=%h addr=%h wr=%b exp 2/44/0", ahbm_htrans, ahbm_haddr, ahbm_hwrite);
    end
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin tests_failed++; $display("FAIL err_rsp got v=%b err=%b exp 1/1", rsp_valid, rsp_err); end
    tick(); drive_bus(1'b1, 1'b0, 32'h12345678); @(negedge clk); // cycle 5
    tests_run++; if (rsp_valid !== 1'b0 || ahbm_htrans !== IDLE) begin tests_failed++; $display("FAIL err_c5 got v=%b trans=%h exp 0/0", rsp_valid, ahbm_htrans); end
    tick(); drive_bus(1'b1, 1'b0, '0); @(negedge clk); // cycle 6
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h12345678) begin
      tests_failed++; $display("FAIL err_retry_rsp got v=%b err=%b rdata=%h exp 1/0/12345678", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_byte_write();
    tick(); drive_cmd(1'b1, 32'h3, 1'b1, 3'd0, 32'hAB00_0000); drive_bus(1'b1, 1'b0, '0);
    tick(); drive_cmd(1'b0, '0, 1'b0, 3'd0, '0); @(negedge clk);
    tests_run++; if (ahbm_hsize !== 3'd0 || ahbm_haddr !== 32'h3 || ahbm_htrans !== NONSEQ) begin
      tests_failed++; $display("FAIL byte_aphase got size=%0d addr=%h trans=%h exp 0/3/2", ahbm_hsize, ahbm_haddr, ahbm_htrans);
    end
    tick(); @(negedge clk);
    tests_run++; if (ahbm_hwdata !== 32'hAB00_0000) begin tests_failed++; $display("FAIL byte_hwdata got %h exp ab000000", ahbm_hwdata); end
    tick(); @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin tests_failed++; $display("FAIL byte_rsp got v=%b err=%b exp 1/0", rsp_valid, rsp_err); end
  endtask

  task automatic test_reset_mid_transfer();
    tick(); drive_cmd(1'b1, 32'h80, 1'b0, 3'd2, '0); drive_bus(1'b1, 1'b0, '0);
    tick(); drive_cmd(1'b0, '0, 1'b0, 3'd0, '0);
    tick(); drive_bus(1'b0, 1'b0, '0); rst_n = 1'b0; // waited data phase
    tick(); rst_n = 1'b1; drive_bus(1'b1, 1'b0, 32'h7777_7777); @(negedge clk);
    tests_run++; if (ahbm_htrans !== IDLE || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++; $display("FAIL mid_rst got trans=%h rv=%b rdy=%b exp 0/0/1", ahbm_htrans, rsp_valid, cmd_ready);
    end
    tick(); @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_rsp got %b exp 0", rsp_valid); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_single_write();
    idle_cycles(2);
    test_back_to_back();
    idle_cycles(2);
    test_wait_states();
    idle_cycles(2);
    test_error();
    idle_cycles(2);
    test_byte_write();
    idle_cycles(2);
    test_reset_mid_transfer();
    idle_cycles(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
